// File: rtl/seq_age_arbiter_pkg.sv
// Shared sequence-number helpers for the age arbiter.
//   SEQ_MAX_BITS : widest sequence number the helpers handle
//   ST_EMPTY/FULL: output register states
//   seq_dist()   : modular distance of a sequence number from the oldest one
package seq_age_arbiter_pkg;

    localparam int SEQ_MAX_BITS = 32;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // (seq - oldest) mod 2^bits; smaller distance means older.
    function automatic logic [SEQ_MAX_BITS-1:0] seq_dist(
        input logic [SEQ_MAX_BITS-1:0] seq,
        input logic [SEQ_MAX_BITS-1:0] oldest,
        input int                      bits
    );
        logic [SEQ_MAX_BITS-1:0] mask;
        mask = (bits >= SEQ_MAX_BITS) ? '1 : ((32'd1 << bits) - 32'd1);
        return (seq - oldest) & mask;
    endfunction

endpackage

// File: rtl/seq_age_cmp.sv
// Pairwise age comparator used as a node of the arbitration tree.
//   a_seq, b_seq : candidate sequence numbers (a is the lower-index side)
//   oldest       : current oldest in-flight sequence number
//   a_older      : 1 when a is at least as old as b (ties favour a)
module seq_age_cmp
    import seq_age_arbiter_pkg::*;
#(
    parameter int p_seq_num_bits = 5
) (
    input  logic [p_seq_num_bits-1:0] a_seq,
    input  logic [p_seq_num_bits-1:0] b_seq,
    input  logic [p_seq_num_bits-1:0] oldest,
    output logic                      a_older
);

    logic [SEQ_MAX_BITS-1:0] a_dist;
    logic [SEQ_MAX_BITS-1:0] b_dist;

    assign a_dist  = seq_dist(SEQ_MAX_BITS'(a_seq), SEQ_MAX_BITS'(oldest), p_seq_num_bits);
    assign b_dist  = seq_dist(SEQ_MAX_BITS'(b_seq), SEQ_MAX_BITS'(oldest), p_seq_num_bits);
    assign a_older = (a_dist <= b_dist);

endmodule

// File: rtl/seq_age_arbiter.sv
// Oldest-first arbiter with a one-entry output register.
//   clk, rst                  : clock, async active-low reset
//   req_val/req_rdy           : per-requester handshake
//   req_seq_num/req_msg       : per-requester age tag and payload
//   gnt_val/gnt_rdy           : granted entry handshake
//   gnt_seq_num/msg/idx       : granted entry fields (registered)
//   commit_val/commit_seq_num : commit; oldest becomes commit_seq_num + 1
//   oldest_seq_num            : current oldest in-flight sequence number
module seq_age_arbiter
    import seq_age_arbiter_pkg::*;
#(
    parameter int p_seq_num_bits = 5,
    parameter int p_num_reqs     = 4,
    parameter int p_msg_bits     = 32
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [p_num_reqs-1:0]                        req_val,
    output logic [p_num_reqs-1:0]                        req_rdy,
    input  logic [p_num_reqs-1:0][p_seq_num_bits-1:0]    req_seq_num,
    input  logic [p_num_reqs-1:0][p_msg_bits-1:0]        req_msg,
    output logic                                         gnt_val,
    input  logic                                         gnt_rdy,
    output logic [p_seq_num_bits-1:0]                    gnt_seq_num,
    output logic [p_msg_bits-1:0]                        gnt_msg,
    output logic [$clog2(p_num_reqs)-1:0]                gnt_idx,
    input  logic                                         commit_val,
    input  logic [p_seq_num_bits-1:0]                    commit_seq_num,
    output logic [p_seq_num_bits-1:0]                    oldest_seq_num
);

    localparam int SB = p_seq_num_bits;
    localparam int IW = $clog2(p_num_reqs);
    localparam int NP = 1 << IW;      // leaves, padded to a power of two
    localparam int NN = 2 * NP - 1;   // heap-ordered tree nodes, root at 0

    logic [0:0]    state_q;
    logic [SB-1:0] oldest_q;
    logic          win_val;
    logic [SB-1:0] win_seq;
    logic [IW-1:0] win_idx;
    logic          accept;

    // Leaves sit in index order, so preferring the left child on a tie
    // resolves equal ages to the lowest requester index.
    for (genvar k = 0; k < NN; k++) begin : g_nd
        logic          v;
        logic [SB-1:0] s;
        logic [IW-1:0] ix;
        if (k >= NP - 1) begin : g_leaf
            localparam int L = k - (NP - 1);
            if (L < p_num_reqs) begin : g_real
                assign v = req_val[L];
                assign s = req_seq_num[L];
            end else begin : g_pad
                assign v = 1'b0;
                assign s = '0;
            end
            assign ix = IW'(L);
        end else begin : g_int
            logic l_older;
            logic pick_l;
            seq_age_cmp #(.p_seq_num_bits(SB)) u_cmp (
                .a_seq   (g_nd[2*k+1].s),
                .b_seq   (g_nd[2*k+2].s),
                .oldest  (oldest_q),
                .a_older (l_older)
            );
            assign pick_l = g_nd[2*k+1].v && (!g_nd[2*k+2].v || l_older);
            assign v      = g_nd[2*k+1].v || g_nd[2*k+2].v;
            assign s      = pick_l ? g_nd[2*k+1].s  : g_nd[2*k+2].s;
            assign ix     = pick_l ? g_nd[2*k+1].ix : g_nd[2*k+2].ix;
        end
    end

    assign win_val = g_nd[0].v;
    assign win_seq = g_nd[0].s;
    assign win_idx = g_nd[0].ix;

    // Selection uses the registered oldest, so a same-cycle commit only
    // affects the next cycle's ranking.
    assign accept = rst && win_val && ((state_q == ST_EMPTY) || gnt_rdy);

    always_comb begin
        req_rdy = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            req_rdy[i] = accept && (win_idx == IW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            oldest_q    <= '0;
            gnt_seq_num <= '0;
            gnt_msg     <= '0;
            gnt_idx     <= '0;
        end else begin
            if (commit_val) begin
                oldest_q <= commit_seq_num + SB'(1);
            end
            if (accept) begin
                state_q     <= ST_FULL;
                gnt_seq_num <= win_seq;
                gnt_msg     <= req_msg[win_idx];
                gnt_idx     <= win_idx;
            end else if ((state_q == ST_FULL) && gnt_rdy) begin
                state_q <= ST_EMPTY;
            end
        end
    end

    assign gnt_val        = (state_q == ST_FULL);
    assign oldest_seq_num = oldest_q;

endmodule

// File: tb/tb_seq_age_arbiter.sv
module tb_seq_age_arbiter;

    localparam int SB = 5;
    localparam int NR = 4;
    localparam int MB = 32;
    localparam int MOD = 1 << SB;

    logic                     clk;
    logic                     rst;
    logic [NR-1:0]            req_val;
    logic [NR-1:0]            req_rdy;
    logic [NR-1:0][SB-1:0]    req_seq_num;
    logic [NR-1:0][MB-1:0]    req_msg;
    logic                     gnt_val;
    logic                     gnt_rdy;
    logic [SB-1:0]            gnt_seq_num;
    logic [MB-1:0]            gnt_msg;
    logic [1:0]               gnt_idx;
    logic                     commit_val;
    logic [SB-1:0]            commit_seq_num;
    logic [SB-1:0]            oldest_seq_num;

    seq_age_arbiter #(.p_seq_num_bits(SB), .p_num_reqs(NR), .p_msg_bits(MB)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_val        (req_val),
        .req_rdy        (req_rdy),
        .req_seq_num    (req_seq_num),
        .req_msg        (req_msg),
        .gnt_val        (gnt_val),
        .gnt_rdy        (gnt_rdy),
        .gnt_seq_num    (gnt_seq_num),
        .gnt_msg        (gnt_msg),
        .gnt_idx        (gnt_idx),
        .commit_val     (commit_val),
        .commit_seq_num (commit_seq_num),
        .oldest_seq_num (oldest_seq_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one-entry holding register plus oldest pointer.
    bit          m_full;
    int          m_oldest;
    int          m_seq;
    int          m_idx;
    logic [31:0] m_msg;
    logic [3:0]  rdy_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full   = 1'b0;
        m_oldest = 0;
    endtask

    // One clock: check combinational/registered outputs at the negedge
    // against the model, then advance the model at the posedge.
    task automatic cycle();
        int   w, bd, d;
        bit   acc;
        logic [3:0] er;
        @(negedge clk);
        w  = -1;
        bd = MOD;
        for (int i = 0; i < NR; i++) begin
            if (req_val[i]) begin
                d = (int'(req_seq_num[i]) - m_oldest + MOD) % MOD;
                if (d < bd) begin
                    bd = d;
                    w  = i;
                end
            end
        end
        acc      = (w >= 0) && (!m_full || gnt_rdy);
        er       = acc ? 4'(1 << w) : 4'd0;
        rdy_seen = req_rdy;
        chk("req_rdy", 64'(req_rdy), 64'(er));
        chk("gnt_val", 64'(gnt_val), 64'(m_full));
        chk("oldest", 64'(oldest_seq_num), 64'(m_oldest));
        if (m_full) begin
            chk("gnt_seq", 64'(gnt_seq_num), 64'(m_seq));
            chk("gnt_idx", 64'(gnt_idx), 64'(m_idx));
            chk("gnt_msg", 64'(gnt_msg), 64'(m_msg));
        end
        @(posedge clk);
        if (commit_val) m_oldest = (int'(commit_seq_num) + 1) % MOD;
        if (acc) begin
            m_full = 1'b1;
            m_seq  = int'(req_seq_num[w]);
            m_idx  = w;
            m_msg  = req_msg[w];
        end else if (m_full && gnt_rdy) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    task automatic set_req(input int i, input int seq, input logic [31:0] msg);
        req_seq_num[i] = SB'(seq);
        req_msg[i]     = msg;
    endtask

    initial begin
        rst            = 1'b0;
        req_val        = 4'b1111;
        req_seq_num    = '0;
        req_msg        = '0;
        gnt_rdy        = 1'b1;
        commit_val     = 1'b0;
        commit_seq_num = '0;
        model_reset();

        // Reset state, with requests pending.
        #12;
        chk("rst_gnt_val", 64'(gnt_val), 64'd0);
        chk("rst_oldest", 64'(oldest_seq_num), 64'd0);
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        chk("rst_gnt_seq", 64'(gnt_seq_num), 64'd0);
        chk("rst_gnt_msg", 64'(gnt_msg), 64'd0);
        chk("rst_gnt_idx", 64'(gnt_idx), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic age ordering: seq 1 beats seq 3.
        req_val = 4'b0011;
        set_req(0, 3, 32'hA000_0000);
        set_req(1, 1, 32'hA000_0001);
        cycle();
        chk("basic_rdy", 64'(rdy_seen), 64'b0010);
        chk("basic_gval", 64'(gnt_val), 64'd1);
        chk("basic_gseq", 64'(gnt_seq_num), 64'd1);
        chk("basic_gidx", 64'(gnt_idx), 64'd1);
        req_val = 4'b0000;
        cycle();

        // Wrap: oldest=30 so 31 is older than 2.
        commit_val = 1'b1;
        commit_seq_num = SB'(29);
        cycle();
        commit_val = 1'b0;
        chk("wrap_oldest", 64'(oldest_seq_num), 64'd30);
        req_val = 4'b0101;
        set_req(0, 2, 32'hB000_0000);
        set_req(2, 31, 32'hB000_0002);
        cycle();
        chk("wrap_gseq1", 64'(gnt_seq_num), 64'd31);
        chk("wrap_gidx1", 64'(gnt_idx), 64'd2);
        req_val = 4'b0001;
        cycle();
        chk("wrap_gseq2", 64'(gnt_seq_num), 64'd2);
        req_val = 4'b0000;
        cycle();

        // Backpressure: held entry stays put, no acceptance.
        req_val = 4'b0001;
        set_req(0, 5, 32'hC0DE_0001);
        cycle();
        set_req(0, 6, 32'hC0DE_0002);
        gnt_rdy = 1'b0;
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("bp_rdy", 64'(rdy_seen), 64'd0);
            chk("bp_msg", 64'(gnt_msg), 64'hC0DE_0001);
            chk("bp_seq", 64'(gnt_seq_num), 64'd5);
        end
        gnt_rdy = 1'b1;
        cycle();
        chk("bp_rel_rdy", 64'(rdy_seen), 64'b0001);
        chk("bp_rel_msg", 64'(gnt_msg), 64'hC0DE_0002);
        req_val = 4'b0000;
        cycle();

        // Tie on equal age: lowest index first.
        req_val = 4'b1001;
        set_req(0, 7, 32'hD000_0000);
        set_req(3, 7, 32'hD000_0003);
        cycle();
        chk("tie_gidx1", 64'(gnt_idx), 64'd0);
        req_val = 4'b1000;
        cycle();
        chk("tie_gidx2", 64'(gnt_idx), 64'd3);
        req_val = 4'b0000;
        commit_val = 1'b1;
        commit_seq_num = SB'(31);
        cycle();
        commit_val = 1'b0;
        chk("pre_coin_oldest", 64'(oldest_seq_num), 64'd0);

        // Coincident commit: ranking uses oldest=0, not 5.
        req_val = 4'b0011;
        set_req(0, 5, 32'hE000_0000);
        set_req(1, 2, 32'hE000_0001);
        commit_val = 1'b1;
        commit_seq_num = SB'(4);
        cycle();
        commit_val = 1'b0;
        chk("coin_gseq", 64'(gnt_seq_num), 64'd2);
        chk("coin_oldest", 64'(oldest_seq_num), 64'd5);
        req_val = 4'b0000;
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            req_val = 4'($urandom);
            for (int i = 0; i < NR; i++) set_req(i, int'($urandom_range(0, MOD - 1)), $urandom);
            gnt_rdy        = ($urandom_range(0, 9) < 7);
            commit_val     = ($urandom_range(0, 4) == 0);
            commit_seq_num = SB'($urandom);
            cycle();
        end

        // Asynchronous reset while holding an entry.
        req_val = 4'b0001;
        set_req(0, 9, 32'hF000_0000);
        gnt_rdy = 1'b0;
        commit_val = 1'b1;
        commit_seq_num = SB'(10);
        cycle();
        commit_val = 1'b0;
        chk("ar_pre_gval", 64'(gnt_val), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_gval", 64'(gnt_val), 64'd0);
        chk("ar_oldest", 64'(oldest_seq_num), 64'd0);
        chk("ar_rdy", 64'(req_rdy), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        gnt_rdy = 1'b1;
        cycle();
        chk("ar_after_gseq", 64'(gnt_seq_num), 64'd9);
        req_val = 4'b0000;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_age_arbiter.md
SEQ_AGE_ARBITER -- requirements
Module: seq_age_arbiter

Interface
REQ-001 SHALL have parameter p_seq_num_bits, default 5, width of a sequence number.
REQ-002 SHALL have parameter p_num_reqs, default 4, number of requesters (>=2).
REQ-003 SHALL have parameter p_msg_bits, default 32, payload width.
REQ-004 SHALL have port clk  input  1  sole clock; all state rises on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have ports req_val[p_num_reqs]  input  1 each  requester valid.
REQ-007 SHALL have ports req_rdy[p_num_reqs]  output  1 each  requester accepted.
REQ-008 SHALL have ports req_seq_num[p_num_reqs]  input  p_seq_num_bits each  requester age tag.
REQ-009 SHALL have ports req_msg[p_num_reqs]  input  p_msg_bits each  requester payload.
REQ-010 SHALL have port gnt_val  output  1  granted entry valid.
REQ-011 SHALL have port gnt_rdy  input  1  consumer accepts granted entry.
REQ-012 SHALL have ports gnt_seq_num / gnt_msg / gnt_idx  output  p_seq_num_bits / p_msg_bits / clog2(p_num_reqs)  granted entry fields.
REQ-013 SHALL have ports commit_val, commit_seq_num  input  1, p_seq_num_bits  commit notification.
REQ-014 SHALL have port oldest_seq_num  output  p_seq_num_bits  current oldest in-flight sequence number.

Function
REQ-015 SHALL hold oldest register; on commit_val, oldest <= commit_seq_num + 1 modulo 2^p_seq_num_bits (wraps 2^bits-1 -> 0).
REQ-016 SHALL rank requester by distance d = (req_seq_num - oldest) mod 2^p_seq_num_bits; smaller d is older.
REQ-017 SHALL select, each cycle, the valid requester with smallest d; ties -> lowest index.
REQ-018 SHALL use the pre-update oldest value for selection when commit_val coincides with arbitration.
REQ-019 SHALL contain a one-entry output register with two states: EMPTY (gnt_val=0) and FULL (gnt_val=1).
REQ-020 SHALL accept a winner when EMPTY, or when FULL and gnt_rdy=1 (same-cycle drain-and-refill).
REQ-021 SHALL assert req_rdy only for the selected winner and only when accepting; at most one req_rdy high per cycle.
REQ-022 SHALL present an accepted entry on gnt_* the cycle after acceptance (latency 1).
REQ-023 SHALL hold gnt_seq_num, gnt_msg, gnt_idx stable while gnt_val=1 and gnt_rdy=0.
REQ-024 SHALL transition FULL->EMPTY on gnt_rdy=1 with no valid requester; EMPTY->FULL on any accepted winner.
REQ-025 SHALL not re-rank a held entry against newly arriving older requests (no preemption).
REQ-026 SHALL drive req_rdy combinationally from req_val, req_seq_num, oldest, state, gnt_rdy; no combinational path from req_* to gnt_*.

Reset
REQ-027 SHALL, while rst=0, immediately force state EMPTY, gnt_val=0, oldest=0, all req_rdy=0.
REQ-028 SHALL reset gnt_seq_num, gnt_msg, gnt_idx to 0.
REQ-029 SHALL discard any held entry on reset asserted mid-operation; no commit is lost-tracked.

Structure
REQ-030 SHALL place the distance function and width constants in a shared sequence-number package.
REQ-031 SHALL use one sub-module, seq_age_cmp (two sequence numbers + oldest -> is_older), instantiated as a reduction tree.
REQ-032 SHALL keep the output register and oldest register in the top module.

Verification (p_seq_num_bits=5, p_num_reqs=4)
REQ-033 SHALL test: after reset, req0 seq 3, req1 seq 1 -> req_rdy[1]=1 only; next cycle gnt_val=1, gnt_seq_num=1, gnt_idx=1.
REQ-034 SHALL test wrap: commit 29 (oldest=30); req0 seq 2, req2 seq 31 -> gnt_seq_num=31, gnt_idx=2; then gnt_seq_num=2.
REQ-035 SHALL test backpressure: gnt_rdy=0 for 3 cycles with req0 valid -> gnt_* stable, req_rdy all 0; gnt_rdy=1 -> req_rdy[0]=1 same cycle, new entry next cycle.
REQ-036 SHALL test tie: req0 and req3 both seq 7 -> gnt_idx=0; next grant gnt_idx=3.
REQ-037 SHALL test coincident commit: oldest=0, commit 4 same cycle as req0 seq 5, req1 seq 2 -> gnt_seq_num=2; oldest_seq_num=5 next cycle.
REQ-038 SHALL test async reset while gnt_val=1 -> gnt_val=0 and oldest_seq_num=0 before next clk edge.
